// File: rtl/axi_lite_default_slave.sv
// AXI4-Lite default slave: accepts every access, answers with a fixed error response, counts responses.
// Define AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN to add first-error address capture ports.
module axi_lite_default_slave #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [1:0]  RESP_CODE  = 2'b11,
  parameter logic [31:0] RDATA_FILL = 32'hDEADBEEF,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [CNT_WIDTH-1:0]  wr_err_count,
  output logic [CNT_WIDTH-1:0]  rd_err_count,
  output logic                  err_pulse
`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
  ,
  output logic                  first_err_valid,
  output logic                  first_err_is_write,
  output logic [ADDR_WIDTH-1:0] first_err_addr
`endif
);

  typedef enum logic { W_ACCEPT, W_RESP } w_state_t;
  typedef enum logic { R_ACCEPT, R_RESP } r_state_t;

  w_state_t w_state_reg;
  r_state_t r_state_reg;
  logic     enable_reg;
  logic     aw_got_reg;
  logic     w_got_reg;
  logic     bvalid_reg;
  logic     rvalid_reg;
  logic     err_pulse_reg;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [1:0] resp_hs;
  logic [CNT_WIDTH-1:0] cnt_reg [2];
  logic [DATA_WIDTH-1:0] fill_word;

  // Read data is the 32-bit fill pattern repeated across the bus width.
  for (genvar gi = 0; gi < DATA_WIDTH / 32; gi++) begin : g_fill
    assign fill_word[gi*32 +: 32] = RDATA_FILL;
  end

  assign s_axi_awready = enable_reg && (w_state_reg == W_ACCEPT) && !aw_got_reg;
  assign s_axi_wready  = enable_reg && (w_state_reg == W_ACCEPT) && !w_got_reg;
  assign s_axi_arready = enable_reg && (r_state_reg == R_ACCEPT);
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_bresp   = RESP_CODE;
  assign s_axi_rresp   = RESP_CODE;
  assign s_axi_rdata   = fill_word;
  assign err_pulse     = err_pulse_reg;
  assign wr_err_count  = cnt_reg[0];
  assign rd_err_count  = cnt_reg[1];

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign b_hs    = bvalid_reg && s_axi_bready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = rvalid_reg && s_axi_rready;
  assign resp_hs = {r_hs, b_hs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg <= 1'b0;
    end else begin
      enable_reg <= 1'b1;
    end
  end

  // AW and W are collected independently; the response issues once both have arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_reg <= W_ACCEPT;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      bvalid_reg  <= 1'b0;
    end else begin
      case (w_state_reg)
        W_ACCEPT: begin
          if ((aw_got_reg || aw_hs) && (w_got_reg || w_hs)) begin
            w_state_reg <= W_RESP;
            bvalid_reg  <= 1'b1;
            aw_got_reg  <= 1'b0;
            w_got_reg   <= 1'b0;
          end else begin
            aw_got_reg <= aw_got_reg || aw_hs;
            w_got_reg  <= w_got_reg || w_hs;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state_reg <= W_ACCEPT;
            bvalid_reg  <= 1'b0;
          end
        end
        default: w_state_reg <= W_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_reg <= R_ACCEPT;
      rvalid_reg  <= 1'b0;
    end else begin
      case (r_state_reg)
        R_ACCEPT: begin
          if (ar_hs) begin
            r_state_reg <= R_RESP;
            rvalid_reg  <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_state_reg <= R_ACCEPT;
            rvalid_reg  <= 1'b0;
          end
        end
        default: r_state_reg <= R_ACCEPT;
      endcase
    end
  end

  // Index 0 counts B responses, index 1 counts R responses; both stick at all-ones.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (resp_hs[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= b_hs || r_hs;
    end
  end

`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
  logic                  cap_valid_reg;
  logic                  cap_is_write_reg;
  logic [ADDR_WIDTH-1:0] cap_addr_reg;

  // Only the first address handshake after reset is kept; a write beats a same-cycle read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_valid_reg    <= 1'b0;
      cap_is_write_reg <= 1'b0;
      cap_addr_reg     <= '0;
    end else if (!cap_valid_reg && (aw_hs || ar_hs)) begin
      cap_valid_reg    <= 1'b1;
      cap_is_write_reg <= aw_hs;
      cap_addr_reg     <= aw_hs ? s_axi_awaddr : s_axi_araddr;
    end
  end

  assign first_err_valid    = cap_valid_reg;
  assign first_err_is_write = cap_is_write_reg;
  assign first_err_addr     = cap_addr_reg;

  logic unused_inputs;
  assign unused_inputs = ^s_axi_wdata;
`else
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_wdata, s_axi_awaddr, s_axi_araddr};
`endif

endmodule

// File: tb/tb_axi_lite_default_slave.sv
// Randomized self-checking bench for axi_lite_default_slave with a transaction-count reference model.
module tb_axi_lite_default_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CMAX = 15;
  localparam logic [1:0] RESP = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, err_pulse;
  logic [1:0] bresp, rresp;
  logic [CW-1:0] wr_cnt, rd_cnt;
`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
  logic cap_valid, cap_is_write;
  logic [AW-1:0] cap_addr;
`endif

  axi_lite_default_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_CODE(RESP),
                           .RDATA_FILL(32'hDEADBEEF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .wr_err_count(wr_cnt), .rd_err_count(rd_cnt), .err_pulse(err_pulse)
`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
    , .first_err_valid(cap_valid), .first_err_is_write(cap_is_write), .first_err_addr(cap_addr)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts of accepted AW/W/AR and completed B/R since reset.
  bit m_en, m_pulse;
  int m_aw, m_w, m_b, m_ar, m_r;
  bit m_cap_v, m_cap_w;
  logic [AW-1:0] m_cap_a;

  function automatic bit e_awready(); return m_en && (m_aw == m_b); endfunction
  function automatic bit e_wready();  return m_en && (m_w == m_b);  endfunction
  function automatic bit e_bvalid();  return (m_aw > m_b) && (m_w > m_b); endfunction
  function automatic bit e_arready(); return m_en && (m_ar == m_r); endfunction
  function automatic bit e_rvalid();  return m_ar > m_r; endfunction
  function automatic int sat(input int v); return (v > CMAX) ? CMAX : v; endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en <= 0; m_pulse <= 0;
      m_aw <= 0; m_w <= 0; m_b <= 0; m_ar <= 0; m_r <= 0;
      m_cap_v <= 0; m_cap_w <= 0; m_cap_a <= '0;
    end else begin
      m_en <= 1;
      if (awvalid && e_awready()) m_aw <= m_aw + 1;
      if (wvalid && e_wready()) m_w <= m_w + 1;
      if (bready && e_bvalid()) m_b <= m_b + 1;
      if (arvalid && e_arready()) m_ar <= m_ar + 1;
      if (rready && e_rvalid()) m_r <= m_r + 1;
      m_pulse <= (bready && e_bvalid()) || (rready && e_rvalid());
      if (!m_cap_v && awvalid && e_awready()) begin
        m_cap_v <= 1; m_cap_w <= 1; m_cap_a <= awaddr;
      end else if (!m_cap_v && arvalid && e_arready()) begin
        m_cap_v <= 1; m_cap_w <= 0; m_cap_a <= araddr;
      end
    end
  end

  // Compare process: every negedge outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("awready", awready, e_awready());
      chk("wready", wready, e_wready());
      chk("bvalid", bvalid, e_bvalid());
      chk("bresp", bresp, RESP);
      chk("arready", arready, e_arready());
      chk("rvalid", rvalid, e_rvalid());
      chk("rresp", rresp, RESP);
      chk("rdata", rdata, 32'hDEADBEEF);
      chk("wr_err_count", wr_cnt, sat(m_b));
      chk("rd_err_count", rd_cnt, sat(m_r));
      chk("err_pulse", err_pulse, m_pulse);
`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
      chk("first_err_valid", cap_valid, m_cap_v);
      if (m_cap_v) begin
        chk("first_err_is_write", cap_is_write, m_cap_w);
        chk("first_err_addr", cap_addr, m_cap_a);
      end
`endif
    end
  end

  task automatic cyc(); @(negedge clk); endtask

  task automatic idle();
    awvalid = 0; wvalid = 0; arvalid = 0;
  endtask

  task automatic reset_now();
    #2 rst = 1;
    #1;
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_err_pulse", err_pulse, 0);
`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
    chk("rst_first_err_valid", cap_valid, 0);
`endif
    cyc();
    rst = 0;
  endtask

  initial begin
    repeat (2) cyc();
    chk("reset_awready", awready, 0);
    chk("reset_bvalid", bvalid, 0);
    rst = 0;
    cyc();
    chk("enabled_awready", awready, 1);

    // Same-cycle AW and W, bready held high.
    awaddr = 32'h1000; wdata = 32'hA5A5A5A5; awvalid = 1; wvalid = 1; bready = 1;
    cyc();
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 2'b11);
    chk("t1_pulse_before", err_pulse, 0);
    idle();
    cyc();
    chk("t1_bvalid_done", bvalid, 0);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_pulse", err_pulse, 1);
    cyc();
    chk("t1_pulse_drop", err_pulse, 0);

    // W first, AW later, B held off.
    bready = 0; wvalid = 1;
    cyc();
    chk("t2_wready_drop", wready, 0);
    wvalid = 0;
    repeat (2) cyc();
    awvalid = 1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t2_bvalid_hold", bvalid, 1);
      chk("t2_awready_block", awready, 0);
      cyc();
    end
    awvalid = 0; bready = 1;
    cyc();
    chk("t2_bvalid_done", bvalid, 0);
    chk("t2_wr_cnt", wr_cnt, 2);

    // Read with rready held off.
    araddr = 32'h2000; arvalid = 1; rready = 0;
    cyc();
    arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_rvalid", rvalid, 1);
      chk("t3_rdata", rdata, 32'hDEADBEEF);
      chk("t3_rresp", rresp, 2'b11);
      chk("t3_arready", arready, 0);
      cyc();
    end
    rready = 1;
    cyc();
    chk("t3_rvalid_done", rvalid, 0);
    chk("t3_rd_cnt", rd_cnt, 1);

    // Concurrent write and read, B and R complete together.
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    cyc();
    chk("t4_bvalid", bvalid, 1);
    chk("t4_rvalid", rvalid, 1);
    idle();
    cyc();
    chk("t4_wr_cnt", wr_cnt, 3);
    chk("t4_rd_cnt", rd_cnt, 2);
    chk("t4_pulse", err_pulse, 1);
    cyc();
    chk("t4_pulse_drop", err_pulse, 0);

    // 20 back-to-back reads push the 4-bit counter into saturation.
    arvalid = 1; rready = 1;
    repeat (40) cyc();
    arvalid = 0;
    cyc();
    chk("t5_rd_sat", rd_cnt, 15);

    // Reset while a write response is pending.
    bready = 0; awvalid = 1; wvalid = 1;
    cyc();
    idle();
    chk("t6_bvalid_pending", bvalid, 1);
    reset_now();
    cyc();
`ifdef AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN
    awaddr = 32'h30; araddr = 32'h40; awvalid = 1; wvalid = 1; arvalid = 1;
    cyc();
    idle();
    chk("t7_cap_valid", cap_valid, 1);
    chk("t7_cap_is_write", cap_is_write, 1);
    chk("t7_cap_addr", cap_addr, 32'h30);
`endif
    bready = 1; rready = 1;
    repeat (3) cyc();

    // Randomized traffic with occasional asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      awvalid = ($urandom_range(0, 3) != 0);
      wvalid  = ($urandom_range(0, 3) != 0);
      arvalid = ($urandom_range(0, 2) != 0);
      bready  = ($urandom_range(0, 2) != 0);
      rready  = ($urandom_range(0, 2) != 0);
      awaddr  = $urandom;
      araddr  = $urandom;
      wdata   = $urandom;
      if ($urandom_range(0, 299) == 0) reset_now();
      else cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_default_slave.md
Name: axi_lite_default_slave

Overview:
- Parametrised AXI4-Lite terminator. It is the next generation of the master-side tie-off.
- It attaches to an unused or unmapped AXI4-Lite master port, for example an interconnect default-slave slot or a spare shell control port.
- It completes every transaction with a programmable error response, so masters never hang on an unmapped region.
- It counts the errors it issues, to aid debug of stray host/driver accesses.

Parameters:
- ADDR_WIDTH, 32: width of awaddr/araddr.
- DATA_WIDTH, 32: width of wdata/rdata; must be 32 or 64.
- RESP_CODE, 2'b11: bresp/rresp value returned (DECERR default; 2'b10 = SLVERR).
- RDATA_FILL, 32'hDEADBEEF: read-data pattern; replicated to DATA_WIDTH.
- CNT_WIDTH, 16: width of the error counters.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: asynchronous, active-high reset.
- s_axi_awaddr, input, ADDR_WIDTH: write address (ignored unless capture enabled).
- s_axi_awvalid, input, 1: write address valid.
- s_axi_awready, output, 1: write address ready.
- s_axi_wdata, input, DATA_WIDTH: write data (discarded).
- s_axi_wvalid, input, 1: write data valid.
- s_axi_wready, output, 1: write data ready.
- s_axi_bresp, output, 2: write response.
- s_axi_bvalid, output, 1: write response valid.
- s_axi_bready, input, 1: write response ready.
- s_axi_araddr, input, ADDR_WIDTH: read address (ignored unless capture enabled).
- s_axi_arvalid, input, 1: read address valid.
- s_axi_arready, output, 1: read address ready.
- s_axi_rdata, output, DATA_WIDTH: read data.
- s_axi_rresp, output, 2: read response.
- s_axi_rvalid, output, 1: read valid.
- s_axi_rready, input, 1: read ready.
- wr_err_count, output, CNT_WIDTH: completed B responses, saturating.
- rd_err_count, output, CNT_WIDTH: completed R responses, saturating.
- err_pulse, output, 1: one-cycle strobe per cycle in which any B or R handshake completes.

Behaviour:
- Reset (async assert, sync release):
  - All readies, bvalid, rvalid, err_pulse = 0; counters = 0.
  - bresp/rresp = RESP_CODE constant; rdata = fill constant.
  - A registered enable rises on the first clk edge after rst deasserts; all readies stay 0 until it is set.
- Write channel, states W_ACCEPT and W_RESP, with flags aw_got and w_got:
  - W_ACCEPT: awready = enable & !aw_got; wready = enable & !w_got.
  - AW and W handshakes are independent and may occur in either order or in the same cycle.
  - When both are complete (flag set or handshake this cycle), move to W_RESP at that edge: bvalid = 1, flags cleared, both readies 0.
  - W_RESP: bvalid held until bready; on handshake return to W_ACCEPT. Readies reassert the following cycle, so at most one write is outstanding.
  - Minimum latency: AW+W handshake at edge N, bvalid visible after edge N; B handshake possible at edge N+1.
- Read channel, states R_ACCEPT and R_RESP:
  - R_ACCEPT: arready = enable.
  - AR handshake moves to R_RESP with rvalid = 1, rdata = fill, rresp = RESP_CODE.
  - rvalid and rdata stay stable until rready; then return to R_ACCEPT. One read outstanding.
- The read and write channels are fully independent; simultaneous activity on both is legal.
- Counters: increment on the respective B/R handshake and saturate at all-ones (no wrap).
  - Simultaneous B and R handshakes increment both counters; err_pulse is a single-cycle 1.
- Valid deasserted by the master before handshake (protocol violation): no state change, no capture.
- Reset mid-transaction: in-flight AW/W/AR state is discarded and outputs return to reset values immediately; no response is issued for lost transactions.

Optional Feature:
- Macro AXI_LITE_DEFAULT_SLAVE_CAPTURE_EN.
- Defined: adds outputs first_err_valid (1), first_err_is_write (1) and first_err_addr (ADDR_WIDTH).
  - Captures the address of the first AW or AR handshake after reset.
  - On a same-cycle AW and AR, the write wins.
  - Held until reset.
- Undefined: these ports and registers are absent; awaddr/araddr are unused.

Test Plan:
- Reset release, then AW(0x1000) and W(0xA5A5A5A5) in the same cycle, bready=1 -> bvalid one cycle later with bresp=2'b11; wr_err_count=1; err_pulse high for 1 cycle.
- W first, AW 3 cycles later, bready held 0 for 5 cycles -> wready drops after the W handshake; bvalid stays high and stable until bready; no second AW is accepted meanwhile.
- AR(0x2000), rready=0 for 4 cycles, then 1 -> rvalid stable, rdata=0xDEADBEEF, rresp=2'b11; rd_err_count=1; arready=0 while rvalid.
- Concurrent write and read whose B and R handshakes land in the same cycle -> both counters +1; err_pulse a single 1-cycle strobe.
- CNT_WIDTH=4: 20 reads -> rd_err_count saturates at 15.
- With capture enabled: AW(0x30) and AR(0x40) in the same cycle -> first_err_addr=0x30, is_write=1. Assert rst while bvalid is high -> bvalid=0 and counters=0 immediately; first_err_valid=0.
